// File: rtl/sobel_stream_scheduler.sv
// sobel_stream_scheduler
// Paces one frame of pixels into the Sobel datapath (camera FIFO or UART
// source) and drains the result FIFO to SDRAM in fixed-length write bursts
// with frame-relative word addresses.
// Optional feature macro: SOBEL_PINGPONG_EN -- when defined, consecutive
// frames alternate between two SDRAM buffers (base 0 / base FRAME_PIXELS).
module sobel_stream_scheduler #(
    parameter int FRAME_PIXELS = 307200,
    parameter int BURST_LEN    = 8,
    parameter int FIFO_HIGH    = 1000,
    parameter int ADDR_W       = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode_static,
    input  logic              cam_empty,
    output logic              cam_rd_en,
    input  logic              uart_rx_done,
    output logic              pix_valid,
    input  logic [9:0]        res_count,
    output logic              res_rd,
    output logic              burst_req,
    output logic [ADDR_W-1:0] burst_addr,
    input  logic              burst_ack,
    output logic              wr_valid,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow
);

    // Counter width holds the value FRAME_PIXELS itself; one extra bit is
    // used for sums so nothing overflows before comparison.
    localparam int CNT_W  = $clog2(FRAME_PIXELS + 1);
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [CNT_W:0]    FRAME_C   = (CNT_W + 1)'(FRAME_PIXELS);
    localparam logic [CNT_W:0]    BURST_C   = (CNT_W + 1)'(BURST_LEN);
    localparam logic [9:0]        HIGH_RC   = 10'(FIFO_HIGH);
    localparam logic [9:0]        BURST_RC  = 10'(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_REQ,
        S_BURST,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic [CNT_W-1:0]   feed_cnt_q, feed_cnt_d;
    logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic               pix_valid_q, pix_valid_d;
    logic               wr_valid_q;
    logic               overflow_q, overflow_d;

    logic               run;
    logic               start_take;
    logic [CNT_W:0]     feed_sum;
    logic               feed_open;
    logic               uart_take;
    logic [CNT_W:0]     wr_next;
    logic [CNT_W:0]     addr_base;
    logic [CNT_W:0]     addr_full;

    assign run        = (state_q != S_IDLE);
    assign start_take = (state_q == S_IDLE) && start;

`ifdef SOBEL_PINGPONG_EN
    logic frame_sel_q, frame_sel_d;

    // Buffer select flips after every completed frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_sel_q <= 1'b0;
        end else begin
            frame_sel_q <= frame_sel_d;
        end
    end

    assign frame_sel_d = frame_done ? ~frame_sel_q : frame_sel_q;
    assign addr_base   = frame_sel_q ? FRAME_C : '0;
`else
    assign addr_base   = '0;
`endif

    // Feed path: a pixel strobe already in flight (pix_valid_q) counts
    // toward the frame so the source is never read one pixel too many.
    always_comb begin
        feed_sum    = {1'b0, feed_cnt_q} + (CNT_W + 1)'(pix_valid_q);
        feed_open   = run && (feed_sum < FRAME_C);
        cam_rd_en   = feed_open && !mode_q && !cam_empty && (res_count < HIGH_RC);
        uart_take   = feed_open && mode_q && uart_rx_done;
        pix_valid_d = cam_rd_en || uart_take;

        feed_cnt_d = feed_cnt_q;
        if (start_take) begin
            feed_cnt_d = '0;
        end else if (pix_valid_q) begin
            feed_cnt_d = feed_cnt_q + CNT_W'(1);
        end

        // UART cannot be throttled, so a pixel arriving above the high
        // watermark is still forwarded but flagged.
        overflow_d = overflow_q;
        if (start_take) begin
            overflow_d = 1'b0;
        end else if (uart_take && (res_count >= HIGH_RC)) begin
            overflow_d = 1'b1;
        end

        mode_d = start_take ? mode_static : mode_q;
    end

    // Feed path registers: source latency stage, pixel count, sticky flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q      <= 1'b0;
            feed_cnt_q  <= '0;
            pix_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            feed_cnt_q  <= feed_cnt_d;
            pix_valid_q <= pix_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    // Drain FSM next-state and Moore outputs.
    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        beat_d     = beat_q;
        burst_req  = 1'b0;
        res_rd     = 1'b0;
        frame_done = 1'b0;
        wr_next    = {1'b0, wr_cnt_q} + BURST_C;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    wr_cnt_d = '0;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                // A whole burst must be buffered so reads never underflow.
                if (res_count >= BURST_RC) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                burst_req = 1'b1;
                if (burst_ack) begin
                    beat_d  = '0;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                res_rd = 1'b1;
                if (beat_q == LAST_BEAT) begin
                    state_d = S_DONE;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            S_DONE: begin
                wr_cnt_d = wr_next[CNT_W-1:0];
                if (wr_next == FRAME_C) begin
                    frame_done = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Drain FSM state register and write-side counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_cnt_q   <= '0;
            beat_q     <= '0;
            wr_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            beat_q     <= beat_d;
            wr_valid_q <= res_rd;
        end
    end

    // Address wraps naturally by truncation to ADDR_W bits.
    assign addr_full  = {1'b0, wr_cnt_q} + addr_base;
    assign burst_addr = burst_req ? ADDR_W'(addr_full) : '0;

    assign pix_valid  = pix_valid_q;
    assign wr_valid   = wr_valid_q;
    assign overflow   = overflow_q;
    assign busy       = run;

endmodule

// File: doc/sobel_stream_scheduler.md
Name: sobel_stream_scheduler

Overview:
Sequences one frame of pixels through the Sobel convolution datapath.
- Paces the camera FIFO (real-time mode) or forwards UART bytes (static mode) as the datapath's per-pixel strobe.
- Throttles input against the result FIFO fill level.
- Drains the result FIFO to SDRAM in fixed-length write bursts with frame-relative addresses.
- Sits between the camera FIFO/UART receiver, the Sobel datapath and the SDRAM controller.

Parameters:
FRAME_PIXELS, 307200, pixels per frame (640x480); must be a multiple of BURST_LEN.
BURST_LEN, 8, result words per SDRAM write burst.
FIFO_HIGH, 1000, result FIFO count at or above which camera reads pause.
ADDR_W, 20, SDRAM word address width.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  pulse; arms processing of one frame from IDLE.
mode_static  input  1  0 = camera FIFO source, 1 = UART source; sampled on start.
cam_empty  input  1  camera FIFO empty.
cam_rd_en  output  1  camera FIFO read strobe.
uart_rx_done  input  1  UART byte-valid pulse.
pix_valid  output  1  per-pixel strobe to the Sobel datapath.
res_count  input  10  result FIFO read-side word count.
res_rd  output  1  result FIFO read strobe.
burst_req  output  1  SDRAM write burst request.
burst_addr  output  ADDR_W  burst start word address.
burst_ack  input  1  SDRAM controller accepts the burst; 1-cycle pulse.
wr_valid  output  1  result word valid to SDRAM, 1 cycle after res_rd.
busy  output  1  high outside IDLE.
frame_done  output  1  1-cycle pulse when the last burst completes.
overflow  output  1  sticky; UART pixel arrived while res_count >= FIFO_HIGH.

Behaviour:
- Reset, async, any state: all outputs 0, counters 0, FSM to IDLE. An in-flight burst is abandoned with no completion.

Feed path (active in RUN, until feed_cnt == FRAME_PIXELS):
- Camera mode: cam_rd_en = !cam_empty && res_count < FIFO_HIGH && feed_cnt < FRAME_PIXELS (combinational). pix_valid = cam_rd_en registered, 1-cycle FIFO latency.
- Static mode: pix_valid = uart_rx_done registered, 1 cycle. cam_rd_en stays 0.
- UART source cannot stall. If uart_rx_done occurs while res_count >= FIFO_HIGH, set overflow; the pixel is still forwarded.
- feed_cnt increments on each pix_valid. Source pulses arriving after feed_cnt reaches FRAME_PIXELS are ignored.

Drain FSM:
- IDLE: on start, latch mode, clear feed_cnt, wr_cnt and the overflow flag, go to WAIT.
- WAIT: when res_count >= BURST_LEN, go to REQ.
- REQ: burst_req = 1 and burst_addr = wr_cnt (plus base, see Optional Feature) held stable until burst_ack. On ack, go to BURST.
- BURST: res_rd = 1 for exactly BURST_LEN consecutive cycles; wr_valid follows 1 cycle later. Go to DONE.
- DONE: one cycle for the last wr_valid. wr_cnt += BURST_LEN. If wr_cnt == FRAME_PIXELS, pulse frame_done and go to IDLE; else go to WAIT.
- RUN (feed enabled) is any state other than IDLE.
- start while busy is ignored.
- burst_ack outside REQ is ignored.
- burst_addr wraps modulo 2^ADDR_W.
- Feed and drain run concurrently. Drain res_rd never coincides with a FIFO underflow because BURST is entered only with res_count >= BURST_LEN.

Optional Feature:
SOBEL_PINGPONG_EN.
- Defined: a frame_sel bit toggles on each frame_done. burst_addr = wr_cnt + (frame_sel ? FRAME_PIXELS : 0), so consecutive frames alternate between two SDRAM buffers. frame_sel resets to 0.
- Undefined: base is always 0; every frame overwrites the same region.

Test Plan:
- Camera mode, cam_empty = 0, res_count held 0: pulse start -> cam_rd_en high from the next cycle; pix_valid lags by 1; feed stops after exactly 307200 pix_valid.
- res_count = 1000 in camera mode -> cam_rd_en = 0 same cycle. res_count = 999 -> cam_rd_en resumes.
- res_count = 8, burst_ack 3 cycles after burst_req -> burst_addr = 0 held over 3 cycles; res_rd high 8 cycles; wr_valid high 8 cycles, offset +1. The next burst_addr is 8.
- Static mode with uart_rx_done while res_count = 1005 -> overflow = 1 and stays 1 until the next start; pix_valid is still issued.
- Full frame, BURST_LEN = 8, FRAME_PIXELS = 64 -> 8 bursts at addresses 0,8,...,56; frame_done is a 1-cycle pulse and busy then falls. With SOBEL_PINGPONG_EN, the second frame's addresses are 64..120.
- rst asserted mid-BURST (after 3 res_rd) -> all outputs 0 immediately. After release, a new start begins at burst_addr 0.
